uart_rx_stream_ctrl: RTL and testbench
======================================

UART_RX_STREAM_CTRL -- requirements
Module: uart_rx_stream_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; power of two, 4..256.
REQ-002 Parameter CNT_W, default $clog2(DEPTH)+1, width of the occupancy count.
REQ-003 i_Clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_Baud_Sel  input  2  baud select: 0=9600, 1=19200, 2=57600, 3=115200.
REQ-006 i_Cfg_Load  input  1  one-cycle pulse; applies i_Baud_Sel.
REQ-007 o_Period  output  20  bit period in clocks, sent to the decoder.
REQ-008 o_Dec_Rst  output  1  active-high synchronous reset to the decoder.
REQ-009 i_Dec_Ready  input  1  decoder holds a finished byte.
REQ-010 i_Dec_Byte  input  8  decoder byte; valid while i_Dec_Ready=1.
REQ-011 o_Dec_Release  output  1  one-cycle pulse that frees the decoder.
REQ-012 o_Data  output  8  FIFO head byte (first-word fall-through).
REQ-013 o_Valid  output  1  FIFO not empty.
REQ-014 i_Ready  input  1  consumer accepts o_Data when o_Valid and i_Ready are both 1.
REQ-015 o_Count  output  CNT_W  FIFO occupancy, 0..DEPTH.
REQ-016 o_Overflow  output  1  sticky; set when a byte is dropped.
REQ-017 i_Clr_Ovf  input  1  clears o_Overflow and o_Drop_Cnt.
REQ-018 o_Drop_Cnt  output  8  dropped-byte count; saturates at 255.

Function
REQ-019 Period table for a 25 MHz clock: sel 0->2604, 1->1302, 2->434, 3->217.
REQ-020 The FSM SHALL have the states IDLE, CAPTURE, WAIT_CLR and CFG_RST.
REQ-021 IDLE: when i_Cfg_Load=1, go to CFG_RST; otherwise, when i_Dec_Ready=1, go to CAPTURE.
REQ-022 CAPTURE (one cycle): push i_Dec_Byte, or drop it; o_Dec_Release=1 (Moore output); go to WAIT_CLR.
REQ-023 WAIT_CLR: return to IDLE once i_Dec_Ready=0. A pending i_Cfg_Load is latched and serviced on the return to IDLE.
REQ-024 CFG_RST: o_Period updates on entry; o_Dec_Rst=1 for exactly 2 cycles; FIFO flushed (count=0); then IDLE.
REQ-025 In CAPTURE or CFG_RST, a new i_Cfg_Load is latched, not lost; the latest i_Baud_Sel at load time wins.
REQ-026 Latency: i_Dec_Ready rises in cycle N -> CAPTURE in N+1 -> o_Valid=1 and o_Data=byte in N+2 (if the FIFO was empty).
REQ-027 Push is permitted if count<DEPTH, or if count=DEPTH and a pop occurs in the same cycle.
REQ-028 Drop (push not permitted): o_Overflow<=1; o_Drop_Cnt increments, saturating at 255.
REQ-029 If i_Clr_Ovf and a drop occur in the same cycle, the drop wins: o_Overflow=1, o_Drop_Cnt=1.
REQ-030 Pop occurs when o_Valid & i_Ready. Simultaneous push and pop leave count unchanged.
REQ-031 Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-032 o_Valid and o_Data SHALL be stable while i_Ready=0.
REQ-033 A flush in CFG_RST overrides any pop in the same cycle.

Reset
REQ-034 On i_Rst_n=0, immediately: state=IDLE, count=0, pointers=0, o_Valid=0, o_Data=0.
REQ-035 On i_Rst_n=0, immediately: o_Overflow=0, o_Drop_Cnt=0, o_Dec_Release=0, pending config cleared.
REQ-036 On i_Rst_n=0, immediately: o_Period=2604 (9600 baud) and o_Dec_Rst=1.
REQ-037 o_Dec_Rst deasserts on the first clock edge after i_Rst_n releases.
REQ-038 Reset during CAPTURE or WAIT_CLR aborts the transfer; the in-flight byte is discarded.

Structure
REQ-039 A shared package SHALL hold: the FSM state enum, the 4-entry period table constants, and the CLK_HZ=25_000_000 constant.
REQ-040 The FIFO SHALL be one sub-module, byte_fifo (DEPTH parameter; push, pop, flush, count), instantiated once.

Verification
REQ-041 Single byte: after reset, decoder presents 0xA5 -> one o_Dec_Release pulse; o_Valid in N+2 with o_Data=0xA5; i_Ready=1 -> count=0.
REQ-042 Overflow: 17 bytes (0x00..0x10) with i_Ready=0 and DEPTH=16 -> count=16; 0x10 dropped; o_Overflow=1; o_Drop_Cnt=1; drain yields 0x00..0x0F in order.
REQ-043 Full plus simultaneous pop: FIFO full, byte 0x55 arrives with i_Ready=1 in the CAPTURE cycle -> no drop; count stays 16; 0x55 is last out.
REQ-044 Reconfig: i_Cfg_Load with sel=3 while in WAIT_CLR holding 3 bytes -> after return to IDLE: o_Period=217, o_Dec_Rst high 2 cycles, count=0.
REQ-045 Reset mid-operation: assert i_Rst_n=0 during CAPTURE -> outputs take reset values immediately; no further release pulse; o_Period=2604.
REQ-046 Drop-counter saturation: 300 drops -> o_Drop_Cnt=255. Then i_Clr_Ovf -> o_Drop_Cnt=0 and o_Overflow=0.

Source files
------------

// File: rtl/uart_rx_stream_ctrl_pkg.sv
// Shared definitions for the UART receive stream controller: FSM states,
// clock frequency and the baud-select to bit-period table.
package uart_rx_stream_ctrl_pkg;

    localparam int CLK_HZ = 25_000_000;

    localparam logic [19:0] PERIOD_9600   = 20'(CLK_HZ / 9600);    // 2604
    localparam logic [19:0] PERIOD_19200  = 20'(CLK_HZ / 19200);   // 1302
    localparam logic [19:0] PERIOD_57600  = 20'(CLK_HZ / 57600);   // 434
    localparam logic [19:0] PERIOD_115200 = 20'(CLK_HZ / 115200);  // 217

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_CLR = 2'd2,
        CFG_RST  = 2'd3
    } state_t;

    function automatic logic [19:0] period_for(input logic [1:0] sel);
        logic [19:0] p;
        case (sel)
            2'd0:    p = PERIOD_9600;
            2'd1:    p = PERIOD_19200;
            2'd2:    p = PERIOD_57600;
            default: p = PERIOD_115200;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_stream_ctrl_byte_fifo.sv
// First-word fall-through byte FIFO with flush; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle, otherwise dropped.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Push,
    input  logic [7:0]       i_Data,
    input  logic             i_Pop,
    input  logic             i_Flush,
    output logic [7:0]       o_Data,
    output logic             o_Valid,
    output logic [CNT_W-1:0] o_Count,
    output logic             o_Drop
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    // Flush wins over any pop issued in the same cycle.
    assign w_pop   = i_Pop && !w_empty && !i_Flush;
    assign w_push  = i_Push && !i_Flush && (!w_full || w_pop);
    assign o_Drop  = i_Push && !i_Flush && !w_push;

    assign o_Valid = !w_empty;
    assign o_Data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign o_Count = r_count;

    always_ff @(posedge i_Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_Data;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_stream_ctrl.sv
// Hands bytes from a UART decoder into a FWFT FIFO, tracks drops, and applies
// baud reconfiguration by resetting the decoder and flushing the FIFO.
module uart_rx_stream_ctrl
    import uart_rx_stream_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic [1:0]       i_Baud_Sel,
    input  logic             i_Cfg_Load,
    output logic [19:0]      o_Period,
    output logic             o_Dec_Rst,
    input  logic             i_Dec_Ready,
    input  logic [7:0]       i_Dec_Byte,
    output logic             o_Dec_Release,
    output logic [7:0]       o_Data,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [CNT_W-1:0] o_Count,
    output logic             o_Overflow,
    input  logic             i_Clr_Ovf,
    output logic [7:0]       o_Drop_Cnt
);
    state_t      r_state;
    state_t      w_state_next;
    logic        r_cfg_pend;
    logic [1:0]  r_cfg_sel;
    logic        r_cfg_cnt;
    logic [19:0] r_period;
    logic        r_dec_rst;
    logic        r_overflow;
    logic [7:0]  r_drop_cnt;
    logic        w_push;
    logic        w_flush;
    logic        w_drop;
    logic        w_enter_cfg;

    always_comb begin
        w_state_next  = r_state;
        o_Dec_Release = 1'b0;
        w_push        = 1'b0;
        w_flush       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_Cfg_Load || r_cfg_pend) w_state_next = CFG_RST;
                else if (i_Dec_Ready)         w_state_next = CAPTURE;
            end
            CAPTURE: begin
                o_Dec_Release = 1'b1;
                w_push        = 1'b1;
                w_state_next  = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!i_Dec_Ready) w_state_next = IDLE;
            end
            CFG_RST: begin
                w_flush = 1'b1;
                if (r_cfg_cnt) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_enter_cfg = (r_state == IDLE) && (w_state_next == CFG_RST);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state    <= IDLE;
            r_cfg_pend <= 1'b0;
            r_cfg_sel  <= 2'd0;
            r_cfg_cnt  <= 1'b0;
            r_period   <= PERIOD_9600;
            r_dec_rst  <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            // Registered so it can read high during reset yet track CFG_RST exactly.
            r_dec_rst <= (w_state_next == CFG_RST);
            r_cfg_cnt <= (r_state == CFG_RST);
            if (w_enter_cfg) begin
                r_period   <= period_for(i_Cfg_Load ? i_Baud_Sel : r_cfg_sel);
                r_cfg_pend <= 1'b0;
            end else if (i_Cfg_Load) begin
                r_cfg_pend <= 1'b1;
                r_cfg_sel  <= i_Baud_Sel;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (i_Clr_Ovf)                r_drop_cnt <= 8'd1;
            else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end else if (i_Clr_Ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Push  (w_push),
        .i_Data  (i_Dec_Byte),
        .i_Pop   (i_Ready),
        .i_Flush (w_flush),
        .o_Data  (o_Data),
        .o_Valid (o_Valid),
        .o_Count (o_Count),
        .o_Drop  (w_drop)
    );

    assign o_Period   = r_period;
    assign o_Dec_Rst  = r_dec_rst;
    assign o_Overflow = r_overflow;
    assign o_Drop_Cnt = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_stream_ctrl.sv
// Directed bench for uart_rx_stream_ctrl: drives the decoder handshake and
// consumer side on falling edges and checks outputs against fixed values.
module tb_uart_rx_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  baud_sel;
    logic        cfg_load;
    logic [19:0] period;
    logic        dec_rst;
    logic        dec_ready;
    logic [7:0]  dec_byte;
    logic        dec_release;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic [4:0]  count;
    logic        overflow;
    logic        clr_ovf;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_stream_ctrl #(.DEPTH(16)) dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Baud_Sel    (baud_sel),
        .i_Cfg_Load    (cfg_load),
        .o_Period      (period),
        .o_Dec_Rst     (dec_rst),
        .i_Dec_Ready   (dec_ready),
        .i_Dec_Byte    (dec_byte),
        .o_Dec_Release (dec_release),
        .o_Data        (data),
        .o_Valid       (valid),
        .i_Ready       (ready),
        .o_Count       (count),
        .o_Overflow    (overflow),
        .i_Clr_Ovf     (clr_ovf),
        .o_Drop_Cnt    (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a falling edge with the DUT in IDLE; returns at the falling
    // edge two cycles later (CAPTURE done, DUT in WAIT_CLR, decoder lowered).
    task automatic send_byte(input logic [7:0] b, input logic rdy_cap, input logic clr_cap);
        dec_ready = 1'b1;
        dec_byte  = b;
        @(negedge clk);
        check("release_pulse", dec_release, 1);
        ready   = rdy_cap;
        clr_ovf = clr_cap;
        @(negedge clk);
        check("release_end", dec_release, 0);
        dec_ready = 1'b0;
        ready     = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    task automatic send_and_idle(input logic [7:0] b);
        send_byte(b, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; baud_sel = 2'd0; cfg_load = 1'b0;
        dec_ready = 1'b0; dec_byte = 8'h00; ready = 1'b0; clr_ovf = 1'b0;

        // Reset values
        @(negedge clk); @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_release", dec_release, 0);
        check("rst_period", period, 2604);
        check("rst_dec_rst", dec_rst, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("dec_rst_release", dec_rst, 0);

        // Single byte, FWFT latency N+2, then pop
        send_byte(8'hA5, 1'b0, 1'b0);
        check("single_valid", valid, 1);
        check("single_data", data, 8'hA5);
        check("single_count", count, 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("single_pop_count", count, 0);
        check("single_pop_valid", valid, 0);

        // Overflow: 17 bytes into 16 slots
        for (int i = 0; i < 17; i++) send_and_idle(8'(i));
        check("ovf_count", count, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_drop", drop_cnt, 1);
        check("ovf_head_stable", data, 8'h00);
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain", data, 32'(i));
            @(negedge clk);
        end
        ready = 1'b0;
        check("ovf_drained", count, 0);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clr_flag", overflow, 0);
        check("ovf_clr_drop", drop_cnt, 0);

        // Full FIFO plus simultaneous pop in the CAPTURE cycle
        for (int i = 0; i < 16; i++) send_and_idle(8'(8'h20 + i));
        check("full_count", count, 16);
        send_byte(8'h55, 1'b1, 1'b0);
        @(negedge clk);
        check("fullpop_count", count, 16);
        check("fullpop_ovf", overflow, 0);
        check("fullpop_drop", drop_cnt, 0);
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("fullpop_drain", data, (i < 15) ? 32'(8'h21 + i) : 32'h55);
            @(negedge clk);
        end
        ready = 1'b0;
        check("fullpop_empty", count, 0);

        // Reconfiguration requested while in WAIT_CLR with 3 bytes held
        send_and_idle(8'h01);
        send_and_idle(8'h02);
        send_byte(8'h03, 1'b0, 1'b0);
        cfg_load = 1'b1; baud_sel = 2'd3;
        @(negedge clk);
        cfg_load = 1'b0; baud_sel = 2'd0;
        check("cfg_idle_count", count, 3);
        check("cfg_idle_period", period, 2604);
        check("cfg_idle_dec_rst", dec_rst, 0);
        @(negedge clk);
        check("cfg_period", period, 217);
        check("cfg_dec_rst_1", dec_rst, 1);
        @(negedge clk);
        check("cfg_dec_rst_2", dec_rst, 1);
        check("cfg_flush", count, 0);
        @(negedge clk);
        check("cfg_dec_rst_end", dec_rst, 0);
        check("cfg_count_end", count, 0);
        check("cfg_period_hold", period, 217);

        // Asynchronous reset while in CAPTURE
        send_and_idle(8'h66);
        check("prerst_count", count, 1);
        dec_ready = 1'b1; dec_byte = 8'h77;
        @(negedge clk);
        check("midrst_capture", dec_release, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_release", dec_release, 0);
        check("midrst_dec_rst", dec_rst, 1);
        check("midrst_period", period, 2604);
        check("midrst_count", count, 0);
        check("midrst_valid", valid, 0);
        check("midrst_data", data, 0);
        dec_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_dec_rst", dec_rst, 0);
        check("postrst_release", dec_release, 0);
        @(negedge clk);
        check("postrst_release2", dec_release, 0);
        check("postrst_count", count, 0);

        // Drop counter saturation, clear-vs-drop priority, clear
        for (int i = 0; i < 16; i++) send_and_idle(8'(8'h80 + i));
        for (int i = 0; i < 300; i++) begin
            send_and_idle(8'hEE);
            if (i == 253) check("sat_254", drop_cnt, 254);
        end
        check("sat_drop", drop_cnt, 255);
        check("sat_ovf", overflow, 1);
        check("sat_count", count, 16);
        send_byte(8'hEF, 1'b0, 1'b1);
        check("clrdrop_ovf", overflow, 1);
        check("clrdrop_cnt", drop_cnt, 1);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("sat_clr_drop", drop_cnt, 0);
        check("sat_clr_ovf", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
